// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scanner: segment type, hex glyph table
// and the nibble-to-glyph lookup.
package seven_segment_pkg;

    // Segment pattern, bit6 = a ... bit0 = g, active-high.
    typedef logic [6:0] seg7_t;

    localparam seg7_t GLYPHS [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

    function automatic seg7_t hex_to_seg(input logic [3:0] nib);
        return GLYPHS[nib];
    endfunction

endpackage

// File: rtl/seven_segment_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph decoder.
module seven_segment_hex_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    // Pure table lookup on the currently scanned nibble.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment display scanner with per-frame input snapshot
// and an all-off guard interval after every digit switch.
// Optional feature: define SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN to darken
// leading zero digits (digit 0 is never blanked).
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int clk_mhz    = 50,
    parameter int w_digit    = 6,
    parameter int refresh_hz = 1000,
    parameter int guard_cyc  = 4
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*w_digit-1:0]   number,
    input  logic [w_digit-1:0]     dots,
    input  logic [w_digit-1:0]     en,
    output logic [7:0]             abcdefgh,
    output logic [w_digit-1:0]     digit
);

    localparam int PERIOD = clk_mhz * 1_000_000 / (refresh_hz * w_digit);
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IDX_W  = (w_digit > 1) ? $clog2(w_digit) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] GUARD    = CNT_W'(guard_cyc);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(w_digit - 1);

    // The guard interval must leave at least one lit cycle per digit slot.
    if (PERIOD <= guard_cyc + 1) begin : g_period_check
        $error("seven_segment_scanner: period %0d too short for guard_cyc %0d", PERIOD, guard_cyc);
    end

    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 tick;
    logic [4*w_digit-1:0] number_s;
    logic [w_digit-1:0]   dots_s;
    logic [w_digit-1:0]   en_s;
    logic [3:0]           nib;
    seg7_t                seg;
    logic                 lit;
    logic                 dot;

    assign tick = (cnt == CNT_LAST);
    assign nib  = number_s[{idx, 2'b00} +: 4];

`ifdef SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every enabled digit above it hold zero.
    function automatic logic [w_digit-1:0] lz_blank(input logic [4*w_digit-1:0] nibs,
                                                      input logic [w_digit-1:0]   ens);
        logic [w_digit-1:0] b;
        logic               above_zero;
        b          = '0;
        above_zero = 1'b1;
        for (int i = w_digit - 1; i >= 1; i--) begin
            b[i] = above_zero && (nibs[4*i +: 4] == 4'h0);
            if (ens[i] && (nibs[4*i +: 4] != 4'h0)) above_zero = 1'b0;
        end
        return b;
    endfunction

    logic [w_digit-1:0] blank;
    assign blank = lz_blank(number_s, en_s);
    assign lit   = (cnt >= GUARD) && en_s[idx] && !blank[idx];
    assign dot   = dots_s[idx] && !blank[idx];
`else
    assign lit   = (cnt >= GUARD) && en_s[idx];
    assign dot   = dots_s[idx];
`endif

    seven_segment_hex_decoder u_dec (
        .nibble (nib),
        .seg    (seg)
    );

    // Slot counter and digit index; the index advances once per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Inputs are captured only at the end of a frame so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_s <= '0;
            dots_s   <= '0;
            en_s     <= '0;
        end else if (tick && (idx == IDX_LAST)) begin
            number_s <= number;
            dots_s   <= dots;
            en_s     <= en;
        end
    end

    // Registered display bus, one cycle behind cnt/idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abcdefgh <= 8'h00;
            digit    <= '0;
        end else begin
            abcdefgh <= {seg, dot};
            digit    <= lit ? (w_digit'(1) << idx) : '0;
        end
    end

endmodule
